// File: rtl/regfile_pkg.sv
// Shared defaults and helpers for the multi-port register file.
package regfile_pkg;

  localparam int unsigned XLEN_DEF     = 32;
  localparam int unsigned NUM_REGS_DEF = 32;
  localparam int unsigned ZERO_REG     = 0;

  // Address width needed to index n registers (minimum 1 bit).
  function automatic int unsigned regfile_aw(input int unsigned n);
    int unsigned w;
    w = 1;
    for (int unsigned i = 1; i < 32; i++) begin
      if ((32'd1 << i) < n) w = i + 1;
    end
    return w;
  endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// Pending-write scoreboard: one busy bit per register plus a registered popcount.
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int unsigned NUM_REGS = NUM_REGS_DEF,
  parameter int unsigned NUM_WR   = 2,
  parameter int unsigned AW       = regfile_aw(NUM_REGS_DEF)
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 alloc_en_i,
  input  logic [AW-1:0]        alloc_addr_i,
  input  logic [NUM_WR-1:0]    wr_en_i,
  input  logic [NUM_WR*AW-1:0] wr_addr_i,
  output logic [NUM_REGS-1:0]  busy_vec_o,
  output logic [AW:0]          busy_cnt_o
);

  logic [NUM_REGS-1:0] busy_q, busy_d;
  logic [AW:0]         cnt_q, cnt_d;
  logic                rel;
  logic                nxt;

  // Next busy bits (alloc beats release) and the popcount of that next state.
  always_comb begin
    busy_d = '0;
    cnt_d  = '0;
    rel    = 1'b0;
    nxt    = 1'b0;
    for (int unsigned r = 0; r < NUM_REGS; r++) begin
      rel = 1'b0;
      for (int unsigned j = 0; j < NUM_WR; j++) begin
        if (wr_en_i[j] && (wr_addr_i[j*AW +: AW] == AW'(r))) rel = 1'b1;
      end
      if (alloc_en_i && (alloc_addr_i == AW'(r))) nxt = 1'b1;
      else if (rel)                               nxt = 1'b0;
      else                                        nxt = busy_q[r];
      busy_d[r] = nxt & (r != ZERO_REG);
      cnt_d     = cnt_d + {{AW{1'b0}}, busy_d[r]};
    end
  end

  // Scoreboard state register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      busy_q <= '0;
      cnt_q  <= '0;
    end else begin
      busy_q <= busy_d;
      cnt_q  <= cnt_d;
    end
  end

  assign busy_vec_o = busy_q;
  assign busy_cnt_o = cnt_q;

endmodule

// File: rtl/register_file_mp.sv
// Multi-port integer register file with write-to-read bypass and RAW scoreboard.
module register_file_mp
  import regfile_pkg::*;
#(
  parameter int unsigned XLEN     = XLEN_DEF,
  parameter int unsigned NUM_REGS = NUM_REGS_DEF,
  parameter int unsigned NUM_RD   = 2,
  parameter int unsigned NUM_WR   = 2,
  localparam int unsigned AW      = regfile_aw(NUM_REGS)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NUM_RD*AW-1:0]   rs_addr,
  output logic [NUM_RD*XLEN-1:0] rd_data,
  output logic [NUM_RD-1:0]      rs_busy,
  input  logic [NUM_WR-1:0]      wr_en,
  input  logic [NUM_WR*AW-1:0]   wr_addr,
  input  logic [NUM_WR*XLEN-1:0] wr_data,
  input  logic                   alloc_en,
  input  logic [AW-1:0]          alloc_addr,
  output logic [NUM_REGS-1:0]    busy_vec,
  output logic [AW:0]            busy_cnt
);

  if (NUM_REGS < 2 || (NUM_REGS & (NUM_REGS - 1)) != 0) begin : g_bad_num_regs
    $error("register_file_mp: NUM_REGS must be a power of two >= 2");
  end
  if (NUM_RD < 1 || NUM_WR < 1) begin : g_bad_ports
    $error("register_file_mp: NUM_RD and NUM_WR must be >= 1");
  end

  logic [XLEN-1:0] regs_q [NUM_REGS];
  logic [XLEN-1:0] regs_d [NUM_REGS];
  logic [AW-1:0]   ra;
  logic [XLEN-1:0] rv;

  // Apply writes in ascending port order so the highest-index port wins.
  always_comb begin
    regs_d = regs_q;
    for (int unsigned j = 0; j < NUM_WR; j++) begin
      if (wr_en[j] && (wr_addr[j*AW +: AW] != AW'(ZERO_REG)))
        regs_d[wr_addr[j*AW +: AW]] = wr_data[j*XLEN +: XLEN];
    end
  end

  // Register storage.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) regs_q <= '{default: '0};
    else        regs_q <= regs_d;
  end

  // Combinational reads with same-cycle bypass; x0 is hardwired to zero.
  always_comb begin
    rd_data = '0;
    rs_busy = '0;
    ra      = '0;
    rv      = '0;
    for (int unsigned i = 0; i < NUM_RD; i++) begin
      ra = rs_addr[i*AW +: AW];
      rv = regs_q[ra];
      for (int unsigned j = 0; j < NUM_WR; j++) begin
        if (wr_en[j] && (wr_addr[j*AW +: AW] == ra)) rv = wr_data[j*XLEN +: XLEN];
      end
      if (ra == AW'(ZERO_REG)) rv = '0;
      rd_data[i*XLEN +: XLEN] = rv;
      rs_busy[i]              = busy_vec[ra];
    end
  end

  regfile_scoreboard #(
    .NUM_REGS (NUM_REGS),
    .NUM_WR   (NUM_WR),
    .AW       (AW)
  ) u_scoreboard (
    .clk_i        (clk),
    .rst_ni       (reset),
    .alloc_en_i   (alloc_en),
    .alloc_addr_i (alloc_addr),
    .wr_en_i      (wr_en),
    .wr_addr_i    (wr_addr),
    .busy_vec_o   (busy_vec),
    .busy_cnt_o   (busy_cnt)
  );

endmodule

// File: tb/tb_register_file_mp.sv
// Self-checking bench for register_file_mp: directed table, async reset, random vs model.
module tb_register_file_mp;

  localparam int XLEN = 32;
  localparam int NREG = 32;
  localparam int AW   = 5;

  logic            clk = 1'b0;
  logic            reset;
  logic [2*AW-1:0] rs_addr;
  logic [2*XLEN-1:0] rd_data;
  logic [1:0]      rs_busy;
  logic [1:0]      wr_en;
  logic [2*AW-1:0] wr_addr;
  logic [2*XLEN-1:0] wr_data;
  logic            alloc_en;
  logic [AW-1:0]   alloc_addr;
  logic [NREG-1:0] busy_vec;
  logic [AW:0]     busy_cnt;

  always #5 clk = ~clk;

  register_file_mp #(
    .XLEN     (XLEN),
    .NUM_REGS (NREG),
    .NUM_RD   (2),
    .NUM_WR   (2)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .rs_addr    (rs_addr),
    .rd_data    (rd_data),
    .rs_busy    (rs_busy),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .alloc_en   (alloc_en),
    .alloc_addr (alloc_addr),
    .busy_vec   (busy_vec),
    .busy_cnt   (busy_cnt)
  );

  int pass_cnt  = 0;
  int total_cnt = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // ---------------- reference model ----------------
  logic [31:0] m_mem  [NREG];
  bit          m_busy [NREG];

  task automatic model_reset();
    for (int r = 0; r < NREG; r++) begin
      m_mem[r]  = '0;
      m_busy[r] = 1'b0;
    end
  endtask

  // Highest-index enabled writer to the address supplies the data, else storage.
  function automatic logic [31:0] model_read(input logic [4:0] a);
    if (a == 0) return 32'd0;
    if (wr_en[1] && wr_addr[9:5] == a) return wr_data[63:32];
    if (wr_en[0] && wr_addr[4:0] == a) return wr_data[31:0];
    return m_mem[a];
  endfunction

  function automatic logic [31:0] model_bv();
    logic [31:0] v;
    for (int r = 0; r < NREG; r++) v[r] = m_busy[r];
    return v;
  endfunction

  function automatic int model_cnt();
    int c;
    c = 0;
    for (int r = 0; r < NREG; r++) c += int'(m_busy[r]);
    return c;
  endfunction

  // Clock edge: writes in port order, releases, then allocation overrides.
  task automatic model_edge();
    logic [4:0] a0, a1;
    a0 = wr_addr[4:0];
    a1 = wr_addr[9:5];
    if (wr_en[0]) begin m_mem[a0] = wr_data[31:0];  m_busy[a0] = 1'b0; end
    if (wr_en[1]) begin m_mem[a1] = wr_data[63:32]; m_busy[a1] = 1'b0; end
    if (alloc_en) m_busy[alloc_addr] = 1'b1;
    m_mem[0]  = '0;
    m_busy[0] = 1'b0;
  endtask

  task automatic check_model(input string tag);
    chk({tag, " rd0"}, rd_data[31:0],  model_read(rs_addr[4:0]));
    chk({tag, " rd1"}, rd_data[63:32], model_read(rs_addr[9:5]));
    chk({tag, " rs_busy"}, {30'd0, rs_busy}, {30'd0, m_busy[rs_addr[9:5]], m_busy[rs_addr[4:0]]});
    chk({tag, " busy_vec"}, busy_vec, model_bv());
    chk({tag, " busy_cnt"}, {26'd0, busy_cnt}, 32'(model_cnt()));
  endtask

  task automatic idle();
    wr_en = '0; wr_addr = '0; wr_data = '0; alloc_en = 1'b0; alloc_addr = '0; rs_addr = '0;
  endtask

  // ---------------- directed table ----------------
  typedef struct {
    logic [1:0]  we;
    logic [4:0]  wa0, wa1;
    logic [31:0] wd0, wd1;
    logic        al;
    logic [4:0]  aa;
    logic [4:0]  ra0, ra1;
    logic [31:0] e_rd0, e_rd1;
    logic [1:0]  e_busy;
    logic [31:0] e_bv;
    logic [5:0]  e_cnt;
  } vec_t;

  vec_t tbl [11];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    //           we     wa0 wa1 wd0       wd1       al  aa ra0 ra1 e_rd0     e_rd1     busy   bv     cnt
    tbl[0]  = '{2'b00, 0,  0,  0,        0,        0,  0, 1,  2,  0,        0,        2'b00, 0,     0};
    tbl[1]  = '{2'b01, 1,  0,  100,      0,        0,  0, 3,  0,  0,        0,        2'b00, 0,     0};
    tbl[2]  = '{2'b10, 0,  2,  0,        200,      0,  0, 1,  7,  100,      0,        2'b00, 0,     0};
    tbl[3]  = '{2'b00, 0,  0,  0,        0,        0,  0, 1,  2,  100,      200,      2'b00, 0,     0};
    tbl[4]  = '{2'b11, 5,  5,  'hAAAA,   'hBBBB,   0,  0, 5,  5,  'hBBBB,   'hBBBB,   2'b00, 0,     0};
    tbl[5]  = '{2'b11, 0,  0,  300,      300,      1,  0, 5,  0,  'hBBBB,   0,        2'b00, 0,     0};
    tbl[6]  = '{2'b00, 0,  0,  0,        0,        1,  3, 0,  3,  0,        0,        2'b00, 0,     0};
    tbl[7]  = '{2'b01, 3,  0,  33,       0,        1,  4, 3,  4,  33,       0,        2'b01, 'h08,  1};
    tbl[8]  = '{2'b10, 0,  4,  0,        44,       1,  4, 3,  4,  33,       44,       2'b10, 'h10,  1};
    tbl[9]  = '{2'b00, 0,  0,  0,        0,        0,  0, 4,  3,  44,       33,       2'b01, 'h10,  1};
    tbl[10] = '{2'b00, 0,  0,  0,        0,        0,  0, 5,  0,  'hBBBB,   0,        2'b00, 'h10,  1};

    idle();
    reset = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;

    for (int k = 0; k < 11; k++) begin
      @(negedge clk);
      wr_en      = tbl[k].we;
      wr_addr    = {tbl[k].wa1, tbl[k].wa0};
      wr_data    = {tbl[k].wd1, tbl[k].wd0};
      alloc_en   = tbl[k].al;
      alloc_addr = tbl[k].aa;
      rs_addr    = {tbl[k].ra1, tbl[k].ra0};
      #2;
      chk($sformatf("vec%0d rd0", k),      rd_data[31:0],      tbl[k].e_rd0);
      chk($sformatf("vec%0d rd1", k),      rd_data[63:32],     tbl[k].e_rd1);
      chk($sformatf("vec%0d rs_busy", k),  {30'd0, rs_busy},   {30'd0, tbl[k].e_busy});
      chk($sformatf("vec%0d busy_vec", k), busy_vec,           tbl[k].e_bv);
      chk($sformatf("vec%0d busy_cnt", k), {26'd0, busy_cnt},  {26'd0, tbl[k].e_cnt});
      @(posedge clk);
      model_edge();
    end

    // Async reset mid-flight: regs 1..3 hold data, registers 4 and 6 reserved.
    @(negedge clk);
    idle();
    alloc_en = 1'b1; alloc_addr = 5'd6;
    @(posedge clk);
    @(negedge clk);
    idle();
    rs_addr = {5'd3, 5'd1};
    #1;
    chk("pre-rst busy_cnt", {26'd0, busy_cnt}, 32'd2);
    chk("pre-rst rd0", rd_data[31:0], 32'd100);
    #1;
    reset = 1'b0;
    #1;
    chk("async rd0", rd_data[31:0], 32'd0);
    chk("async rd1", rd_data[63:32], 32'd0);
    chk("async busy_vec", busy_vec, 32'd0);
    chk("async busy_cnt", {26'd0, busy_cnt}, 32'd0);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    model_reset();

    // Randomized traffic against the model; narrow address window forces collisions.
    for (int n = 0; n < 600; n++) begin
      logic [4:0] a [5];
      @(negedge clk);
      for (int q = 0; q < 5; q++)
        a[q] = ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'($urandom_range(0, 7));
      wr_en      = 2'($urandom);
      wr_addr    = {a[1], a[0]};
      wr_data    = {$urandom, $urandom};
      alloc_en   = ($urandom_range(0, 2) != 0);
      alloc_addr = a[2];
      rs_addr    = ($urandom_range(0, 3) == 0) ? {a[1], a[0]} : {a[4], a[3]};
      #2;
      check_model($sformatf("rnd%0d", n));
      @(posedge clk);
      model_edge();
    end

    @(negedge clk);
    idle();
    #2;
    check_model("final");
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/register_file_mp.md
Name: register_file_mp

Overview:
- Parametrised successor of the single-write, dual-read RISC-V integer register file.
- Provides configurable width, depth and read/write port counts, with same-cycle write-to-read bypass.
- Adds a per-register pending-write scoreboard so the pipeline issue stage can detect RAW hazards.
- Sits between decode/issue (reads, reservations) and writeback (writes, reservation release).

Parameters:
XLEN, 32, data width of each register
NUM_REGS, 32, number of architectural registers (power of two, >=2)
NUM_RD, 2, number of read ports
NUM_WR, 2, number of write (writeback) ports
AW, $clog2(NUM_REGS), address width (derived, not overridden)

Ports:
clk  input  1  clock, rising edge
reset  input  1  asynchronous, active-low reset
rs_addr  input  NUM_RD*AW  read addresses, port i at [i*AW +: AW]
rd_data  output  NUM_RD*XLEN  read data, port i at [i*XLEN +: XLEN]
rs_busy  output  NUM_RD  port i address has a pending write
wr_en  input  NUM_WR  write enables
wr_addr  input  NUM_WR*AW  write addresses
wr_data  input  NUM_WR*XLEN  write data
alloc_en  input  1  reserve a destination register (issue)
alloc_addr  input  AW  register being reserved
busy_vec  output  NUM_REGS  scoreboard bit per register
busy_cnt  output  AW+1  number of set scoreboard bits

Behaviour:
- Reset (reset low, asynchronous): all registers cleared to 0, busy_vec = 0, busy_cnt = 0. rd_data reflects stored zeros; rs_busy = 0. Reset asserted mid-operation discards pending writes and reservations immediately.
- Register 0: reads always return 0; writes are ignored; alloc to 0 is ignored; busy_vec[0] is always 0.
- Writes: on a rising edge where wr_en[j] is set, reg[wr_addr[j]] <= wr_data[j].
- Write conflicts: if several enabled ports target the same address, the highest-index port wins.
- Reads: combinational, zero latency.
  - If any enabled write port targets rs_addr[i] (and the address is nonzero), rd_data[i] returns that port's wr_data (bypass, highest index wins).
  - Otherwise rd_data[i] returns the stored value.
- rs_busy[i] = busy_vec[rs_addr[i]] as registered (not bypassed). The issue stage must treat a same-cycle writeback as resolving the hazard by using rd_data, not rs_busy.
- Scoreboard update per edge, per register r != 0:
  - set if alloc_en and alloc_addr == r;
  - else clear if any wr_en[j] with wr_addr[j] == r;
  - else hold.
  - Alloc wins over a simultaneous release of the same register: the new producer is outstanding, so the bit stays 1.
- Writeback to a non-busy register: data is written, bit stays 0, no error.
- Alloc to an already-busy register: bit stays 1, count unchanged.
- busy_cnt: registered popcount of the next busy_vec, updated on the same edge. It never exceeds NUM_REGS-1.
- Latency: write visible in storage the cycle after the edge, and visible via bypass in the same cycle. Busy bit visible the cycle after alloc.
- Parameter checks: NUM_RD >= 1, NUM_WR >= 1. A generate-time $error fires if NUM_REGS is not a power of two.

Decomposition:
- Shared package regfile_pkg holds XLEN and NUM_REGS defaults, the AW derivation function, and the ZERO_REG constant (0).
- One sub-module, regfile_scoreboard: busy_vec, busy_cnt, alloc/release priority.
- Storage, write-conflict resolution and bypass muxing stay in register_file_mp.

Test Plan:
- Reset: hold reset low 2 cycles, release → every rs_addr reads 0, busy_vec = 0, busy_cnt = 0.
- Basic write/read: wr_en[0], addr 1, data 100, one edge; then rs_addr[0] = 1 → rd_data[0] = 100. Same for addr 2, data 200 on port 1 → rd_data[1] = 200.
- Bypass and conflict: same cycle, port 0 writes 5←0xAAAA and port 1 writes 5←0xBBBB, with rs_addr[0] = 5 → rd_data[0] = 0xBBBB combinationally; after the edge, stored value = 0xBBBB.
- x0: write 300 to addr 0 and alloc addr 0 → rd_data = 0, busy_vec[0] = 0, busy_cnt unchanged.
- Scoreboard:
  - alloc 3 → next cycle rs_busy for addr 3 = 1, busy_cnt = 1;
  - alloc 4 plus writeback 3 in the same cycle → busy_cnt = 1, busy_vec = 0x10;
  - alloc 4 plus writeback 4 in the same cycle → busy_vec[4] stays 1.
- Async reset mid-flight: with regs 1..3 written and busy_cnt = 2, drop reset between edges → outputs clear immediately without waiting for a clock edge.
